// File: rtl/crossover.sv
// crossover: breeding stage of the genetic pipeline.
// Latches 10 parent genomes on an accepted start, then writes one child per
// clock into a 50-genome output population: children 0..9 are copies of the
// parents (elitism), children 10..49 are single-point crossovers of two
// LFSR-chosen parents.
// Optional build macro: CROSSOVER_MUTATION_EN -- when defined, every crossover
// child additionally gets one LFSR-chosen bit inverted. The LFSR sequence and
// latency do not depend on the macro.
//
// Handshake: i_start is a level request sampled only in IDLE; o_busy is high
// while children are being written, o_done is high once all 50 are written and
// stays high until i_start is seen low, after which a new run may be requested.
module crossover #(
  parameter int GENOME_W     = 150,
  parameter int NUM_PARENTS  = 10,
  parameter int NUM_CHILDREN = 50
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [GENOME_W*NUM_PARENTS-1:0]  i_sel_pop,
  input  logic [31:0]                      i_prg_seed,
  output logic [GENOME_W*NUM_CHILDREN-1:0] o_new_pop,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [1:0]                       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BREED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [5:0]  LAST_K    = 6'(NUM_CHILDREN - 1);
  localparam logic [5:0]  ELITE_N   = 6'(NUM_PARENTS);

  state_t               r_state;
  logic [5:0]           r_k;
  logic [31:0]          r_lfsr;
  logic [GENOME_W-1:0]  r_par   [NUM_PARENTS];
  logic [GENOME_W-1:0]  r_child [NUM_CHILDREN];
  logic                 r_busy;
  logic                 r_done;

  logic [GENOME_W-1:0]  w_sel   [NUM_PARENTS];
  logic [31:0]          w_lfsr_next;
  logic                 w_elite;
  logic [3:0]           w_elite_idx;
  logic [3:0]           w_a;
  logic [3:0]           w_b;
  logic [7:0]           w_cut;
  logic [GENOME_W-1:0]  w_hi_mask;
  logic [GENOME_W-1:0]  w_cross;
  logic [GENOME_W-1:0]  w_child;
`ifdef CROSSOVER_MUTATION_EN
  logic [7:0]           w_m;
`endif

  // Unpack the flat parent bus and pack the child array onto the output bus.
  for (genvar p = 0; p < NUM_PARENTS; p++) begin : g_unpack
    assign w_sel[p] = i_sel_pop[p*GENOME_W +: GENOME_W];
  end
  for (genvar c = 0; c < NUM_CHILDREN; c++) begin : g_pack
    assign o_new_pop[c*GENOME_W +: GENOME_W] = r_child[c];
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_state = r_state;

  // Galois LFSR step (shift right, taps applied when the shifted-out bit is 1).
  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[31:1]};
    if (r_lfsr[0]) w_lfsr_next = w_lfsr_next ^ LFSR_TAPS;
  end

  // Child for the current k: elite copy, or crossover of parents a/b at cut.
  // Scaling by (byte * N) >> 8 maps a byte uniformly-ish onto 0..N-1.
  always_comb begin
    w_elite     = (r_k < ELITE_N);
    w_elite_idx = w_elite ? r_k[3:0] : 4'd0;
    w_a         = 4'((16'(r_lfsr[7:0])   * 16'(NUM_PARENTS)) >> 8);
    w_b         = 4'((16'(r_lfsr[15:8])  * 16'(NUM_PARENTS)) >> 8);
    w_cut       = 8'((16'(r_lfsr[23:16]) * 16'(GENOME_W))    >> 8);
    // Bits at and above cut come from parent b; cut=0 selects parent b whole.
    w_hi_mask   = {GENOME_W{1'b1}} << w_cut;
    w_cross     = (r_par[w_a] & ~w_hi_mask) | (r_par[w_b] & w_hi_mask);
`ifdef CROSSOVER_MUTATION_EN
    w_m         = 8'((16'(r_lfsr[31:24]) * 16'(GENOME_W))    >> 8);
    w_cross     = w_cross ^ (GENOME_W'(1) << w_m);
`endif
    w_child     = w_elite ? r_par[w_elite_idx] : w_cross;
  end

  // Control FSM with registered outputs; also owns parent, child and LFSR state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_lfsr  <= 32'h1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int p = 0; p < NUM_PARENTS; p++)  r_par[p]   <= '0;
      for (int c = 0; c < NUM_CHILDREN; c++) r_child[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int p = 0; p < NUM_PARENTS; p++) r_par[p] <= w_sel[p];
            // A zero seed would lock the LFSR at zero, so substitute 1.
            r_lfsr  <= (i_prg_seed == 32'h0) ? 32'h1 : i_prg_seed;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BREED;
          end
        end
        S_BREED: begin
          r_child[r_k] <= w_child;
          // Elite copies do not consume randomness.
          if (!w_elite) r_lfsr <= w_lfsr_next;
          r_k <= r_k + 6'd1;
          if (r_k == LAST_K) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossover.sv
// Testbench for crossover: directed runs, a reference population model feeding
// an expected queue, and a monitor that checks each population as done rises.
module tb_crossover;
  localparam int GW = 150;
  localparam int NP = 10;
  localparam int NC = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [GW*NP-1:0]  sel_pop;
  logic [31:0]       seed;
  logic [GW*NC-1:0]  new_pop;
  logic              busy;
  logic              done;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;
  logic [GW*NC-1:0] exp_q[$];
  logic prev_done = 1'b0;

  crossover dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_sel_pop  (sel_pop),
    .i_prg_seed (seed),
    .o_new_pop  (new_pop),
    .o_busy     (busy),
    .o_done     (done),
    .o_state    (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  function automatic logic [GW*NC-1:0] model_pop(input logic [GW*NP-1:0] sp, input logic [31:0] sd);
    logic [31:0] l;
    logic [GW-1:0] pa, pb, ch;
    logic [GW*NC-1:0] r;
    int a, b, cut;
    r = '0;
    l = (sd == 32'h0) ? 32'h1 : sd;
    for (int k = 0; k < NC; k++) begin
      if (k < NP) begin
        ch = sp[k*GW +: GW];
      end else begin
        a   = (int'(l[7:0])   * 10)  >> 8;
        b   = (int'(l[15:8])  * 10)  >> 8;
        cut = (int'(l[23:16]) * 150) >> 8;
        pa  = sp[a*GW +: GW];
        pb  = sp[b*GW +: GW];
        for (int i = 0; i < GW; i++) ch[i] = (i < cut) ? pa[i] : pb[i];
`ifdef CROSSOVER_MUTATION_EN
        begin
          int m;
          m = (int'(l[31:24]) * 150) >> 8;
          ch[m] = ~ch[m];
        end
`endif
        l = lfsr_step(l);
      end
      r[k*GW +: GW] = ch;
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] pat(input int p);
    logic [9:0] w;
    w = 10'(p * 37 + 5);
    return {GW{p[0]}} ^ {15{w}};
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_gen(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input string name, input logic [GW*NC-1:0] act, input logic [GW*NC-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = NC - 1; k >= 0; k--)
      if (act[k*GW +: GW] !== exp[k*GW +: GW]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: child %0d got %h expected %h", name, bad,
               act[bad*GW +: GW], exp[bad*GW +: GW]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_unexpected_done: got done=1 expected no completion");
      end else begin
        chk_pop("monitor_pop", new_pop, exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_state", int'(state), 0);
    chk_pop("rst_pop", new_pop, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full run: start accepted on the next edge, timing and hold checks,
  // then start dropped and done expected to fall one edge later.
  task automatic run(input logic [GW*NP-1:0] sp, input logic [31:0] sd,
                     input bit hold, input bit disturb, input string tag);
    logic [GW*NC-1:0] e;
    int lat, busy_cnt;
    e = model_pop(sp, sd);
    @(negedge clk);
    sel_pop = sp;
    seed    = sd;
    start   = 1'b1;
    exp_q.push_back(e);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (lat == 2)  chk_gen({tag, "_child0_time"},  new_pop[0 +: GW],     e[0 +: GW]);
      if (lat == 12) chk_gen({tag, "_child10_time"}, new_pop[10*GW +: GW], e[10*GW +: GW]);
      if (disturb && lat == 5) begin
        start   = 1'b0;
        sel_pop = ~sp;
        seed    = 32'h5555AAAA;
      end
      if (disturb && lat == 6) start = 1'b1;
    end
    // lat counts negedges after the accepting edge; done after edge T+50.
    chk_int({tag, "_latency"}, lat - 1, 50);
    chk_int({tag, "_busy_cycles"}, busy_cnt, 50);
    if (hold) begin
      repeat (3) @(negedge clk);
      chk_int({tag, "_done_held"}, int'(done), 1);
      chk_pop({tag, "_pop_held"}, new_pop, e);
    end
    start = 1'b0;
    @(negedge clk);
    chk_int({tag, "_done_fall"}, int'(done), 0);
    chk_int({tag, "_state_idle"}, int'(state), 0);
    chk_pop({tag, "_pop_after"}, new_pop, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [GW*NP-1:0] sp_pat, sp_fix, sp_01, sp_zero;
    logic [GW-1:0] hand;

    for (int p = 0; p < NP; p++) begin
      sp_pat[p*GW +: GW] = pat(p);
      sp_fix[p*GW +: GW] = {5{30'(32'h9E3779B9 * (p + 1))}};
      sp_01[p*GW +: GW]  = (p == 0) ? {GW{1'b0}} : {GW{1'b1}};
    end
    sp_zero = '0;
    sel_pop = '0;
    seed    = '0;

    do_reset();

    // Distinct parents, start held high across DONE.
    run(sp_pat, 32'h12345678, 1'b1, 1'b0, "pattern");
    chk_gen("elite_child0", new_pop[0 +: GW],    pat(0));
    chk_gen("elite_child9", new_pop[9*GW +: GW], pat(9));

    // Zero seed behaves like seed 1.
    run(sp_fix, 32'h0, 1'b0, 1'b0, "seed0");
    run(sp_fix, 32'h1, 1'b0, 1'b0, "seed1");

    // 0/1 split parents.
    run(sp_01, 32'hDEADBEEF, 1'b0, 1'b0, "split_dead");
    // Hand-computed: a=9, b=7 -> both all ones.
    hand = {GW{1'b1}};
`ifdef CROSSOVER_MUTATION_EN
    hand[130] = 1'b0;
`endif
    chk_gen("hand_dead_child10", new_pop[10*GW +: GW], hand);

    // Hand-computed: seed 0080FF00 -> a=0, b=9, cut=75, m=0.
    run(sp_01, 32'h0080FF00, 1'b0, 1'b0, "split_hand");
    hand = {{75{1'b1}}, {75{1'b0}}};
`ifdef CROSSOVER_MUTATION_EN
    hand[0] = 1'b1;
`endif
    chk_gen("hand_cut75_child10", new_pop[10*GW +: GW], hand);
    chk_gen("hand_child0_zero", new_pop[0 +: GW], {GW{1'b0}});

    // Start toggled and inputs changed mid-run.
    run(sp_pat, 32'hCAFEF00D, 1'b1, 1'b1, "disturb");

    // Reset during BREED around k=20.
    @(negedge clk);
    sel_pop = sp_fix;
    seed    = 32'h0BADBEEF;
    start   = 1'b1;
    repeat (22) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_int("abort_busy", int'(busy), 0);
    chk_int("abort_done", int'(done), 0);
    chk_int("abort_state", int'(state), 0);
    chk_pop("abort_pop", new_pop, '0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(sp_fix, 32'h0BADBEEF, 1'b0, 1'b0, "after_abort");

    // All-zero parents: elites zero, mutation (if built) is the only set bit.
    run(sp_zero, 32'hDEADBEEF, 1'b0, 1'b0, "zeros");

    repeat (2) @(negedge clk);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossover.md
# crossover

Breeding stage downstream of `selection` in the genetic pipeline. Takes the 10 selected parent genomes (1500-bit `sel_pop`) and builds a full 50-genome population (7500-bit `new_pop`) for the next fitness/selection pass. The 10 parents are carried over unchanged (elitism). The 40 remaining children are formed by single-point crossover of two LFSR-chosen parents. One child is produced per clock.

## Interface
- `GENOME_W`, 150: bits per genome
- `NUM_PARENTS`, 10: genomes in `sel_pop`
- `NUM_CHILDREN`, 50: genomes in `new_pop`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  level request; normally driven by `selection.done`
- `sel_pop`  in  1500  parent genomes; parent p at `[150p+149:150p]`
- `prg_seed`  in  32  LFSR seed, sampled on accepted start
- `new_pop`  out  7500  child genomes; child k at `[150k+149:150k]`
- `busy`  out  1  high in BREED
- `done`  out  1  high in DONE

## Operation
- FSM states: IDLE, BREED, DONE.
- IDLE → BREED when `start`=1. On that edge:
  - latch `sel_pop` into internal parent register;
  - load LFSR with `prg_seed`, or with 32'h1 if `prg_seed`=0;
  - clear child counter k to 0.
- BREED writes one child per edge:
  - k in 0..9: child k = parent k; LFSR holds.
  - k in 10..49: from current LFSR value L:
    - a = (L[7:0]·10)>>8
    - b = (L[15:8]·10)>>8
    - cut = (L[23:16]·150)>>8, range 0..149
    - child bits [cut-1:0] come from parent a; bits [149:cut] from parent b; cut=0 means child = parent b
    - a=b is legal and yields a copy of that parent
    - LFSR advances once on the same edge.
  - k increments each edge. The edge that writes k=49 moves to DONE.
- LFSR: 32-bit Galois, shift right. If bit0=1, XOR with 32'h80200003 after the shift. Never reaches 0.
- DONE: `new_pop` held stable. Stay while `start`=1. Go to IDLE when `start`=0.
- `start` in BREED is ignored. Parents latched at start are unaffected by later `sel_pop` changes.
- `new_pop` changes only on BREED write edges and reset.

## Timing
- Reset (async, immediate):
  - state=IDLE, k=0, LFSR=32'h1, parent register=0;
  - `new_pop`=0, `busy`=0, `done`=0.
- Start accepted on edge T. `busy`=1 after T.
- Child k is visible after edge T+1+k.
- `done`=1 and `busy`=0 after edge T+50. Latency is 50 cycles.
- `done` falls one edge after `start` is seen low in DONE.
- A new run needs `start` low for at least one sampled edge, then high again.
- Reset during BREED aborts the run. Partial children are cleared and there is no `done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `CROSSOVER_MUTATION_EN` defined:
  - each crossover child (k ≥ 10) additionally has one bit inverted;
  - bit position m = (L[31:24]·150)>>8, using the same L as the crossover;
  - elite children are never mutated.
- Undefined: no mutation. Children are pure crossover. The LFSR sequence and latency are identical in both builds.

## Test plan
- Reset mid-BREED (k≈20) → all outputs 0 immediately; state IDLE; next start yields a full 50-cycle run.
- `sel_pop` parent p = {150{p[0]}} pattern distinct per p, `start` held high → children 0..9 equal parents 0..9 exactly; `done` after exactly 50 cycles; `busy` high for 50 cycles.
- `prg_seed`=32'h0 vs 32'h1 → identical `new_pop`.
- Parent 0 = all 0s, parents 1..9 = all 1s, seed 32'hDEADBEEF, mutation undefined → every child k ≥ 10 matches the reference model's a/b/cut computation. Each child is a contiguous 0/1 split or a uniform genome.
- `start` toggled low/high during BREED and `sel_pop` changed → run unaffected; `done` stays high until `start`=0, then drops next cycle; `new_pop` unchanged.
- With `CROSSOVER_MUTATION_EN`, all parents = 0 → each child k ≥ 10 has exactly one bit set, at the model's m; children 0..9 all zero.
